// File: rtl/mux_gate_pkg.sv
// ============================================================================
//  mux_gate_pkg : shared types and constants for the mux-gate BIST.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package mux_gate_pkg;

    // Encodings 6 and 7 are reserved and rejected as bad_op.
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES = 2;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux2x1.sv
// ============================================================================
//  mux2x1   : 2:1 multiplexer cell, the sole primitive of the gate datapath.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mux2x1 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

`default_nettype wire

// File: rtl/mux_gate_bist.sv
// ============================================================================
//  mux_gate_bist : sweeps all 2^W vectors through a mux-built reduction gate
//                  and checks each result against a behavioural reduce.
//  Optional      : MUX_GATE_BIST_FAULT_INJECT_EN enables result inversion at inj_vec.
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module mux_gate_bist
    import mux_gate_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [2:0]   op_i,
    input  logic         inj_en_i,
    input  logic [W-1:0] inj_vec_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         fail_o,
    output logic         bad_op_o,
    output logic [W:0]   err_cnt_o,
    output logic [W-1:0] first_fail_vec_o
);

    localparam logic [W:0] LAST_V     = {1'b0, {W{1'b1}}};
    localparam logic [W:0] ONE_W1     = {{W{1'b0}}, 1'b1};
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t       state_q, state_d;
    logic [W:0]   v_q, v_d;
    logic [1:0]   drain_q, drain_d;
    op_t          op_q;
    logic         w_accept, w_legal;

    assign w_accept = (state_q == IDLE) && start_i;
    assign w_legal  = op_legal(op_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    v_d     = '0;
                    state_d = w_legal ? RUN : DONE;
                end
            end
            RUN: begin
                v_d = v_q + ONE_W1;
                if (v_q == LAST_V) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      op_q <= OP_AND;
        else if (w_accept && w_legal) op_q <= op_t'(op_i);
    end

    // Datapath: three mux chains, a group-select mux pair and an inversion mux.
    logic [W-1:0] w_x;
    logic [W-1:0] w_and_acc, w_or_acc, w_xor_acc;
    logic [1:0]   w_grp;
    logic         w_inv, w_base01, w_base, w_nbase, w_act_raw, w_act, w_exp;

    assign w_x          = v_q[W-1:0];
    assign w_and_acc[0] = w_x[0];
    assign w_or_acc[0]  = w_x[0];
    assign w_xor_acc[0] = w_x[0];

    for (genvar i = 1; i < W; i++) begin : g_chain
        logic w_nacc;
        mux2x1 u_and  (.a_i(1'b0),            .b_i(w_and_acc[i-1]), .sel_i(w_x[i]),         .y_o(w_and_acc[i]));
        mux2x1 u_or   (.a_i(w_or_acc[i-1]),   .b_i(1'b1),           .sel_i(w_x[i]),         .y_o(w_or_acc[i]));
        mux2x1 u_xnot (.a_i(1'b1),            .b_i(1'b0),           .sel_i(w_xor_acc[i-1]), .y_o(w_nacc));
        mux2x1 u_xor  (.a_i(w_xor_acc[i-1]),  .b_i(w_nacc),         .sel_i(w_x[i]),         .y_o(w_xor_acc[i]));
    end

    always_comb begin
        w_grp = 2'b00;
        case (op_q)
            OP_OR, OP_NOR:   w_grp = 2'b01;
            OP_XOR, OP_XNOR: w_grp = 2'b10;
            default:         w_grp = 2'b00;
        endcase
        w_inv = (op_q == OP_NAND) || (op_q == OP_NOR) || (op_q == OP_XNOR);
    end

    mux2x1 u_sel0 (.a_i(w_and_acc[W-1]), .b_i(w_or_acc[W-1]),  .sel_i(w_grp[0]), .y_o(w_base01));
    mux2x1 u_sel1 (.a_i(w_base01),       .b_i(w_xor_acc[W-1]), .sel_i(w_grp[1]), .y_o(w_base));
    mux2x1 u_nbas (.a_i(1'b1),           .b_i(1'b0),           .sel_i(w_base),   .y_o(w_nbase));
    mux2x1 u_inv  (.a_i(w_base),         .b_i(w_nbase),        .sel_i(w_inv),    .y_o(w_act_raw));

`ifdef MUX_GATE_BIST_FAULT_INJECT_EN
    logic         inj_en_q;
    logic [W-1:0] inj_vec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_en_q  <= 1'b0;
            inj_vec_q <= '0;
        end else if (w_accept && w_legal) begin
            inj_en_q  <= inj_en_i;
            inj_vec_q <= inj_vec_i;
        end
    end

    assign w_act = w_act_raw ^ (inj_en_q && (w_x == inj_vec_q));
`else
    logic w_unused_inj;
    assign w_unused_inj = ^{inj_en_i, inj_vec_i};
    assign w_act        = w_act_raw;
`endif

    always_comb begin
        w_exp = 1'b0;
        case (op_q)
            OP_AND:  w_exp = &w_x;
            OP_OR:   w_exp = |w_x;
            OP_XOR:  w_exp = ^w_x;
            OP_NAND: w_exp = ~&w_x;
            OP_NOR:  w_exp = ~|w_x;
            OP_XNOR: w_exp = ~^w_x;
            default: w_exp = 1'b0;
        endcase
    end

    logic         s1_vld_q, s1_exp_q, s1_act_q;
    logic [W-1:0] s1_vec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_vec_q <= '0;
            s1_exp_q <= 1'b0;
            s1_act_q <= 1'b0;
        end else begin
            s1_vld_q <= (state_q == RUN);
            s1_vec_q <= w_x;
            s1_exp_q <= w_exp;
            s1_act_q <= w_act;
        end
    end

    logic         fail_q, bad_op_q;
    logic [W:0]   err_q;
    logic [W-1:0] ffv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q   <= 1'b0;
            bad_op_q <= 1'b0;
            err_q    <= '0;
            ffv_q    <= '0;
        end else if (w_accept) begin
            fail_q   <= ~w_legal;
            bad_op_q <= ~w_legal;
            err_q    <= '0;
            ffv_q    <= '0;
        end else if (s1_vld_q && (s1_exp_q != s1_act_q)) begin
            fail_q <= 1'b1;
            err_q  <= err_q + ONE_W1;
            if (err_q == '0) ffv_q <= s1_vec_q;
        end
    end

    assign busy_o           = (state_q == RUN) || (state_q == DRAIN);
    assign done_o           = (state_q == DONE);
    assign fail_o           = fail_q;
    assign bad_op_o         = bad_op_q;
    assign err_cnt_o        = err_q;
    assign first_fail_vec_o = ffv_q;

endmodule

`default_nettype wire
